// File: rtl/normalize_16bit_left_pkg.sv
// Shared shifter definitions: data width, default exponent width and a
// leading-zero counter used by the left normaliser.
package normalize_16bit_left_pkg;

    localparam int DATA_W    = 16;
    localparam int DEF_EXP_W = 5;
    localparam int LZC_W     = 5;

    // Returns 0..16; 16 means the word is entirely zero.
    function automatic logic [LZC_W-1:0] lzc16(input logic [DATA_W-1:0] value);
        logic [LZC_W-1:0] count;
        logic             found;
        count = LZC_W'(DATA_W);
        found = 1'b0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (!found && value[i]) begin
                count = LZC_W'(DATA_W - 1 - i);
                found = 1'b1;
            end
        end
        return count;
    endfunction

endpackage

// File: rtl/barrel_shift_16bit_left.sv
// Logarithmic 16-bit left barrel shifter; vacated low bits are zero-filled.
module barrel_shift_16bit_left
    import normalize_16bit_left_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [3:0]        ctrl,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        logic [DATA_W-1:0] stage;
        stage = data;
        for (int i = 0; i < 4; i++) begin
            if (ctrl[i]) begin
                stage = stage << (1 << i);
            end
        end
        result = stage;
    end

endmodule

// File: rtl/normalize_16bit_left.sv
// Two-stage valid/ready pipeline that left-normalises a 16-bit mantissa,
// trading exponent for shift and clamping at exponent zero.
module normalize_16bit_left
    import normalize_16bit_left_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [EXP_W-1:0]  in_exp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [EXP_W-1:0]  out_exp,
    output logic [3:0]        out_shamt,
    output logic              out_zero,
    output logic              out_uflow
);

    // Exponent and lzc are compared in a common width so neither side truncates.
    localparam int CMP_W = (EXP_W > LZC_W) ? EXP_W : LZC_W;

    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic [EXP_W-1:0]  s1_exp;
    logic [LZC_W-1:0]  s1_lzc;

    logic              s1_adv;
    logic              s2_adv;

    logic [CMP_W-1:0]  exp_ext;
    logic [CMP_W-1:0]  lzc_ext;
    logic [3:0]        shamt;
    logic [EXP_W-1:0]  nx_exp;
    logic              nx_zero;
    logic              nx_uflow;
    logic [DATA_W-1:0] shifted;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_exp   <= '0;
            s1_lzc   <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= in_data;
                s1_exp  <= in_exp;
                s1_lzc  <= lzc16(in_data);
            end
        end
    end

    assign exp_ext = CMP_W'(s1_exp);
    assign lzc_ext = CMP_W'(s1_lzc);

    // A nonzero word has lzc <= 15, so shifting by lzc[3:0] is exact;
    // when the exponent runs out first the shift stops at the exponent.
    always_comb begin
        shamt    = 4'd0;
        nx_exp   = '0;
        nx_zero  = 1'b0;
        nx_uflow = 1'b0;
        if (s1_data == '0) begin
            nx_zero = 1'b1;
        end else if (lzc_ext <= exp_ext) begin
            shamt  = s1_lzc[3:0];
            nx_exp = EXP_W'(exp_ext - lzc_ext);
        end else begin
            nx_uflow = 1'b1;
            shamt    = (exp_ext > CMP_W'(15)) ? 4'd15 : exp_ext[3:0];
        end
    end

    barrel_shift_16bit_left u_shift (
        .data   (s1_data),
        .ctrl   (shamt),
        .result (shifted)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_exp   <= '0;
            out_shamt <= '0;
            out_zero  <= 1'b0;
            out_uflow <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data  <= shifted;
                out_exp   <= nx_exp;
                out_shamt <= shamt;
                out_zero  <= nx_zero;
                out_uflow <= nx_uflow;
            end
        end
    end

endmodule

// File: tb/tb_normalize_16bit_left.sv
// Scoreboard bench for normalize_16bit_left: directed vector table, latency,
// backpressure, mid-flight reset and randomised traffic.
module tb_normalize_16bit_left;

    localparam int EXP_W = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [15:0]       in_data = '0;
    logic [EXP_W-1:0]  in_exp = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [15:0]       out_data;
    logic [EXP_W-1:0]  out_exp;
    logic [3:0]        out_shamt;
    logic              out_zero;
    logic              out_uflow;

    typedef logic [26:0] res_t;
    typedef struct {
        logic [15:0] din;
        logic [4:0]  ein;
        res_t        want;
    } vec_t;

    int   total = 0;
    int   bad = 0;
    res_t sb[$];
    logic held_valid = 1'b0;
    res_t held;
    bit   rand_done = 1'b0;

    normalize_16bit_left #(.EXP_W(EXP_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_exp    (in_exp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_exp   (out_exp),
        .out_shamt (out_shamt),
        .out_zero  (out_zero),
        .out_uflow (out_uflow)
    );

    always #5 clk = ~clk;

    function automatic res_t packRes(logic [15:0] d, logic [4:0] e, logic [3:0] s, logic z, logic u);
        return {d, e, s, z, u};
    endfunction

    function automatic res_t curRes();
        return packRes(out_data, out_exp, out_shamt, out_zero, out_uflow);
    endfunction

    // Reference: shift one bit at a time, spending exponent, until normalised or exhausted.
    function automatic res_t model(logic [15:0] d, logic [4:0] e);
        int sh;
        if (d == 16'h0000) return packRes(16'h0000, 5'd0, 4'd0, 1'b1, 1'b0);
        sh = 0;
        while (!d[15] && e != 5'd0) begin
            d  = d << 1;
            e  = e - 5'd1;
            sh = sh + 1;
        end
        return packRes(d, e, 4'(sh), 1'b0, !d[15]);
    endfunction

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic applyStimulus(logic [15:0] d, logic [4:0] e, res_t want);
        bit accepted;
        accepted = 1'b0;
        in_data  = d;
        in_exp   = e;
        in_valid = 1'b1;
        for (int c = 0; c < 100 && !accepted; c++) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1'b1;
                sb.push_back(want);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!accepted) begin
            total++;
            bad++;
            $display("[TB] FAIL accept_timeout: data %h never accepted", d);
        end
    endtask

    task automatic waitDrain();
        for (int c = 0; c < 100 && sb.size() != 0; c++) begin
            @(posedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain_timeout: %0d results outstanding, want 0", sb.size());
        end
    endtask

    // Output monitor: checks holding under stall and pops the scoreboard on each transfer.
    always @(negedge clk) begin
        res_t cur;
        if (!rst_n) begin
            held_valid = 1'b0;
        end else if (out_valid) begin
            cur = curRes();
            if (held_valid) checkOutput("hold", 32'(cur), 32'(held));
            if (out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL spurious: got result %h, want none", cur);
                end else begin
                    checkOutput("result", 32'(cur), 32'(sb.pop_front()));
                end
                held_valid = 1'b0;
            end else begin
                held_valid = 1'b1;
                held       = cur;
            end
        end else begin
            held_valid = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t tbl[10];
        tbl[0] = '{16'h0010, 5'd20, packRes(16'h8000, 5'd9,  4'd11, 1'b0, 1'b0)};
        tbl[1] = '{16'h0001, 5'd3,  packRes(16'h0008, 5'd0,  4'd3,  1'b0, 1'b1)};
        tbl[2] = '{16'h0000, 5'd7,  packRes(16'h0000, 5'd0,  4'd0,  1'b1, 1'b0)};
        tbl[3] = '{16'h8001, 5'd5,  packRes(16'h8001, 5'd5,  4'd0,  1'b0, 1'b0)};
        tbl[4] = '{16'h0001, 5'd15, packRes(16'h8000, 5'd0,  4'd15, 1'b0, 1'b0)};
        tbl[5] = '{16'h0001, 5'd31, packRes(16'h8000, 5'd16, 4'd15, 1'b0, 1'b0)};
        tbl[6] = '{16'h00FF, 5'd0,  packRes(16'h00FF, 5'd0,  4'd0,  1'b0, 1'b1)};
        tbl[7] = '{16'h4000, 5'd1,  packRes(16'h8000, 5'd0,  4'd1,  1'b0, 1'b0)};
        tbl[8] = '{16'h1234, 5'd2,  packRes(16'h48D0, 5'd0,  4'd2,  1'b0, 1'b1)};
        tbl[9] = '{16'h0000, 5'd0,  packRes(16'h0000, 5'd0,  4'd0,  1'b1, 1'b0)};

        #12;
        checkOutput("reset_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_result", 32'(curRes()), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("ready_after_reset", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(tbl[i].din, tbl[i].ein, tbl[i].want);
        end
        waitDrain();

        applyStimulus(16'h0010, 5'd20, packRes(16'h8000, 5'd9, 4'd11, 1'b0, 1'b0));
        @(negedge clk);
        checkOutput("latency_cycle1", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("latency_cycle2", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        waitDrain();

        // Backpressure: two words fill both stages, the third must wait.
        out_ready = 1'b0;
        applyStimulus(16'h0100, 5'd10, model(16'h0100, 5'd10));
        applyStimulus(16'h0003, 5'd2,  model(16'h0003, 5'd2));
        in_data  = 16'h7FFF;
        in_exp   = 5'd4;
        in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        applyStimulus(16'h7FFF, 5'd4, packRes(16'hFFFE, 5'd3, 4'd1, 1'b0, 1'b0));
        waitDrain();

        // Reset with two words in flight.
        out_ready = 1'b0;
        applyStimulus(16'h0020, 5'd12, model(16'h0020, 5'd12));
        applyStimulus(16'h0400, 5'd9,  model(16'h0400, 5'd9));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset_valid", 32'(out_valid), 32'd0);
        checkOutput("midreset_result", 32'(curRes()), 32'd0);
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checkOutput("post_reset_valid", 32'(out_valid), 32'd0);
            @(posedge clk);
            #1;
        end

        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [15:0] d;
                    logic [4:0]  e;
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    d = 16'($urandom) >> $urandom_range(0, 16);
                    e = 5'($urandom);
                    applyStimulus(d, e, model(d, e));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        waitDrain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/normalize_16bit_left.md
NORMALIZE_16BIT_LEFT -- requirements
Module: normalize_16bit_left

Interface
REQ-001 SHALL have parameter EXP_W, default 5, exponent field width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  input word is present.
REQ-005 SHALL have port in_ready  output  1  block accepts the input word this cycle.
REQ-006 SHALL have port in_data  input  16  mantissa to normalise.
REQ-007 SHALL have port in_exp  input  EXP_W  unsigned exponent of in_data.
REQ-008 SHALL have port out_valid  output  1  result is present.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-010 SHALL have port out_data  output  16  normalised mantissa.
REQ-011 SHALL have port out_exp  output  EXP_W  adjusted exponent.
REQ-012 SHALL have port out_shamt  output  4  left-shift amount applied.
REQ-013 SHALL have port out_zero  output  1  input mantissa was zero.
REQ-014 SHALL have port out_uflow  output  1  shift was clamped by the exponent (denormal result).

Function
REQ-015 SHALL transfer an input only when in_valid and in_ready are both 1, and a result only when out_valid and out_ready are both 1.
REQ-016 SHALL be a 2-stage pipeline: S1 registers in_data, in_exp and lzc (leading-zero count, 0..16); S2 registers the shifted result and flags.
REQ-017 SHALL have a latency of exactly 2 cycles from input transfer to out_valid when unstalled, and a throughput of 1 word per cycle.
REQ-018 SHALL advance S2 when S2 is empty or out_ready=1, and SHALL advance S1 when S1 is empty or S2 advances.
REQ-019 SHALL drive in_ready = (S1 empty) or (S2 advances), combinationally, with no dependence on in_valid.
REQ-020 SHALL hold out_data, out_exp, out_shamt, out_zero and out_uflow stable while out_valid=1 and out_ready=0.
REQ-021 SHALL, when lzc <= in_exp and in_data != 0, use shamt = lzc and out_exp = in_exp - lzc, with out_uflow=0.
REQ-022 SHALL, when lzc > in_exp and in_data != 0, use shamt = in_exp[3:0] clamped to at most 15, out_exp = 0 and out_uflow = 1.
REQ-023 SHALL, when in_data = 0, drive out_zero=1, out_data=0, out_exp=0, out_shamt=0 and out_uflow=0.
REQ-024 SHALL compute out_data = in_data shifted left by shamt, filling with zeros; the exponent subtraction SHALL never wrap.
REQ-025 SHALL pass an already-normalised input (in_data[15]=1) through unchanged, with shamt=0 and out_exp=in_exp.
REQ-026 SHALL, when accept and output both occur in the same cycle while full, lose no words and duplicate no words.

Reset
REQ-027 SHALL, when rst_n=0, immediately clear the S1 and S2 valid bits and drive out_valid=0 and every result output to 0.
REQ-028 SHALL drive in_ready=1 from the first rising clk edge after rst_n deasserts.
REQ-029 SHALL discard any in-flight words when reset is asserted mid-operation, and SHALL produce no spurious out_valid after reset.

Structure
REQ-030 SHALL take EXP_W and the 16-bit data width constant from the shared shifter package, together with a function for the 16-bit leading-zero count.
REQ-031 SHALL instantiate barrel_shift_16bit_left as its only sub-module, between S1 and S2, with ctrl = shamt.

Verification
REQ-032 SHALL cover: in_data=0x0010, in_exp=20 -> 2 cycles later out_data=0x8000, out_exp=9, out_shamt=11, out_uflow=0.
REQ-033 SHALL cover: in_data=0x0001, in_exp=3 -> out_data=0x0008, out_exp=0, out_shamt=3, out_uflow=1.
REQ-034 SHALL cover: in_data=0x0000, in_exp=7 -> out_zero=1, out_data=0, out_exp=0, out_shamt=0.
REQ-035 SHALL cover: in_data=0x8001, in_exp=5 -> out_data=0x8001, out_exp=5, out_shamt=0.
REQ-036 SHALL cover: 3 back-to-back inputs with out_ready=0 for 4 cycles -> in_ready=0 after 2 accepts, outputs held, then all 3 results delivered in order.
REQ-037 SHALL cover: rst_n pulsed low with 2 words in flight -> out_valid=0 immediately, and no stale result appears after release.
